video_layer_mux: RTL and testbench

VIDEO_LAYER_MUX -- requirements
Module: video_layer_mux

---
 rtl/video_layer_mux.sv | 159 +++++++++++++++
 tb/tb_video_layer_mux.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_layer_mux.sv
// video_layer_mux: two-stage background select plus prioritised overlay compositor.
// Optional macro VIDEO_LAYER_MUX_BLEND_EN turns layer 0 into a 50% blend over the background.
module video_layer_mux #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 24
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  input  logic [1:0]            bg_sel_in,
  input  logic [COLOR_W-1:0]    camera_pixel_in,
  input  logic [COLOR_W/3-1:0]  camera_y_in,
  input  logic [COLOR_W/3-1:0]  channel_in,
  input  logic                  thresholded_pixel_in,
  input  logic [NUM_LAYERS-1:0] layer_hit_in,
  input  logic                  cfg_we_in,
  input  logic [3:0]            cfg_addr_in,
  input  logic [COLOR_W-1:0]    cfg_data_in,
  output logic [COLOR_W-1:0]    pixel_out,
  output logic                  valid_out,
  output logic                  new_frame_out
);

  localparam int CW = COLOR_W / 3;
  localparam logic [COLOR_W-1:0] LAYER_RST =
    {{CW{1'b0}}, {CW{1'b1}}, {CW{1'b0}}};
  localparam logic [COLOR_W-1:0] MASK_RST = COLOR_W'(24'hFF77AA);

  logic [COLOR_W-1:0]    sh_color     [NUM_LAYERS];
  logic [COLOR_W-1:0]    sh_color_nxt [NUM_LAYERS];
  logic [COLOR_W-1:0]    act_color    [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] sh_en, sh_en_nxt, act_en;
  logic [COLOR_W-1:0]    sh_mask, sh_mask_nxt, act_mask;
  logic [1:0]            act_bg;
  logic                  frame_start;

  logic [1:0]            bg_mode;
  logic [COLOR_W-1:0]    mask_col;
  logic [COLOR_W-1:0]    bg_pix;
  logic [COLOR_W-1:0]    s1_pix;
  logic [NUM_LAYERS-1:0] s1_hit;
  logic                  s1_valid, s1_nf;

  logic                  win;
  logic [COLOR_W-1:0]    lay;
  logic [COLOR_W-1:0]    s2_nxt;

  assign frame_start = valid_in & new_frame_in;

  always_comb begin
    sh_color_nxt = sh_color;
    sh_en_nxt    = sh_en;
    sh_mask_nxt  = sh_mask;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cfg_we_in && cfg_addr_in == 4'(i))
        sh_color_nxt[i] = cfg_data_in;
    end
    if (cfg_we_in && cfg_addr_in == 4'd14)
      sh_en_nxt = cfg_data_in[NUM_LAYERS-1:0];
    if (cfg_we_in && cfg_addr_in == 4'd15)
      sh_mask_nxt = cfg_data_in;
  end

  // The frame-start pixel itself must already see the new frame's settings.
  assign bg_mode  = frame_start ? bg_sel_in : act_bg;
  assign mask_col = frame_start ? sh_mask_nxt : act_mask;

  always_comb begin
    bg_pix = camera_pixel_in;
    unique case (bg_mode)
      2'd0: bg_pix = camera_pixel_in;
      2'd1: bg_pix = {channel_in, channel_in, channel_in};
      2'd2: bg_pix = thresholded_pixel_in ? '1 : '0;
      2'd3: bg_pix = thresholded_pixel_in ? mask_col
                   : {camera_y_in, camera_y_in, camera_y_in};
    endcase
  end

  always_comb begin
    win = 1'b0;
    lay = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_hit[i] && act_en[i]) begin
        win = 1'b1;
        lay = act_color[i];
      end
    end
  end

`ifdef VIDEO_LAYER_MUX_BLEND_EN
  logic [CW:0]        sum;
  logic [COLOR_W-1:0] blend;
  logic               win0;

  assign win0 = s1_hit[0] & act_en[0];

  always_comb begin
    sum   = '0;
    blend = '0;
    for (int c = 0; c < 3; c++) begin
      sum = {1'b0, act_color[0][c*CW +: CW]} + {1'b0, s1_pix[c*CW +: CW]};
      blend[c*CW +: CW] = sum[CW:1];
    end
  end

  always_comb begin
    s2_nxt = s1_pix;
    if (win) s2_nxt = lay;
    if (win0) s2_nxt = blend;
  end
`else
  always_comb begin
    s2_nxt = s1_pix;
    if (win) s2_nxt = lay;
  end
`endif

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        sh_color[i]  <= LAYER_RST;
        act_color[i] <= LAYER_RST;
      end
      sh_en         <= '0;
      act_en        <= '0;
      sh_mask       <= MASK_RST;
      act_mask      <= MASK_RST;
      act_bg        <= 2'd0;
      s1_pix        <= '0;
      s1_hit        <= '0;
      s1_valid      <= 1'b0;
      s1_nf         <= 1'b0;
      pixel_out     <= '0;
      valid_out     <= 1'b0;
      new_frame_out <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++)
        sh_color[i] <= sh_color_nxt[i];
      sh_en   <= sh_en_nxt;
      sh_mask <= sh_mask_nxt;
      if (frame_start) begin
        for (int i = 0; i < NUM_LAYERS; i++)
          act_color[i] <= sh_color_nxt[i];
        act_en   <= sh_en_nxt;
        act_mask <= sh_mask_nxt;
        act_bg   <= bg_sel_in;
      end
      s1_pix        <= bg_pix;
      s1_hit        <= layer_hit_in;
      s1_valid      <= valid_in;
      s1_nf         <= new_frame_in;
      pixel_out     <= s2_nxt;
      valid_out     <= s1_valid;
      new_frame_out <= s1_nf;
    end
  end

endmodule

// File: tb/tb_video_layer_mux.sv
// tb_video_layer_mux: random + directed stimulus against a frame-level model.
// Define VIDEO_LAYER_MUX_BLEND_EN for both bench and RTL to exercise blending.
module tb_video_layer_mux;

  localparam int NL = 4;
  localparam int CWD = 24;

`ifdef VIDEO_LAYER_MUX_BLEND_EN
  localparam logic [23:0] E_L0_GREEN = 24'h007F00;
  localparam logic [23:0] E_L0_RED   = 24'h7F0000;
  localparam logic [23:0] E_BLEND    = 24'h7F007F;
`else
  localparam logic [23:0] E_L0_GREEN = 24'h00FF00;
  localparam logic [23:0] E_L0_RED   = 24'hFF0000;
  localparam logic [23:0] E_BLEND    = 24'hFF0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          nf = 1'b0;
  logic [1:0]    bg_sel = '0;
  logic [23:0]   cam = '0;
  logic [7:0]    cam_y = '0;
  logic [7:0]    chan = '0;
  logic          thr = 1'b0;
  logic [NL-1:0] hits = '0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [23:0]   cfg_data = '0;
  logic [23:0]   pixel_out;
  logic          valid_out;
  logic          new_frame_out;

  int checks = 0;
  int errors = 0;

  video_layer_mux #(.NUM_LAYERS(NL), .COLOR_W(CWD)) dut (
    .clk_pixel_in(clk),
    .rst_in(rst),
    .valid_in(valid),
    .new_frame_in(nf),
    .bg_sel_in(bg_sel),
    .camera_pixel_in(cam),
    .camera_y_in(cam_y),
    .channel_in(chan),
    .thresholded_pixel_in(thr),
    .layer_hit_in(hits),
    .cfg_we_in(cfg_we),
    .cfg_addr_in(cfg_addr),
    .cfg_data_in(cfg_data),
    .pixel_out(pixel_out),
    .valid_out(valid_out),
    .new_frame_out(new_frame_out)
  );

  always #5 clk = ~clk;

  // Reference state: shadow and per-frame active configuration.
  logic [23:0]   m_sh_col [NL];
  logic [23:0]   m_col    [NL];
  logic [NL-1:0] m_sh_en, m_en;
  logic [23:0]   m_sh_mask, m_mask;
  logic [1:0]    m_bg;
  logic [25:0]   e0, e1;

  function automatic logic [23:0] blend24(input logic [23:0] a,
                                          input logic [23:0] b);
    logic [23:0] r;
    int x, y;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      x = int'((a >> (8 * c)) & 24'hFF);
      y = int'((b >> (8 * c)) & 24'hFF);
      r = r | (24'((x + y) / 2) << (8 * c));
    end
    return r;
  endfunction

  function automatic logic [23:0] model_px(input logic [1:0] mode,
                                           input logic [23:0] c,
                                           input logic [7:0] y,
                                           input logic [7:0] ch,
                                           input logic t,
                                           input logic [NL-1:0] h);
    logic [23:0] bg;
    case (mode)
      2'd0: bg = c;
      2'd1: bg = {ch, ch, ch};
      2'd2: bg = t ? 24'hFFFFFF : 24'h000000;
      default: bg = t ? m_mask : {y, y, y};
    endcase
    for (int i = 0; i < NL; i++) begin
      if (h[i] && m_en[i]) begin
`ifdef VIDEO_LAYER_MUX_BLEND_EN
        if (i == 0) return blend24(m_col[0], bg);
`endif
        return m_col[i];
      end
    end
    return bg;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        m_sh_col[i] = 24'h00FF00;
        m_col[i] = 24'h00FF00;
      end
      m_sh_en = '0;
      m_en = '0;
      m_sh_mask = 24'hFF77AA;
      m_mask = 24'hFF77AA;
      m_bg = 2'd0;
      e0 = '0;
      e1 = '0;
    end else begin
      if (cfg_we) begin
        if (int'(cfg_addr) < NL) m_sh_col[cfg_addr] = cfg_data;
        else if (cfg_addr == 4'd14) m_sh_en = cfg_data[NL-1:0];
        else if (cfg_addr == 4'd15) m_sh_mask = cfg_data;
      end
      if (valid && nf) begin
        m_bg = bg_sel;
        m_col = m_sh_col;
        m_en = m_sh_en;
        m_mask = m_sh_mask;
      end
      e1 = e0;
      e0 = {valid, nf, model_px(m_bg, cam, cam_y, chan, thr, hits)};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (valid_out !== e1[25] || new_frame_out !== e1[24] ||
          (e1[25] && pixel_out !== e1[23:0])) begin
        errors++;
        $display("FAIL stream t=%0t: got v=%b nf=%b px=%h, want v=%b nf=%b px=%h",
                 $time, valid_out, new_frame_out, pixel_out,
                 e1[25], e1[24], e1[23:0]);
      end
    end
  end

  task automatic lit(input string nm, input logic [23:0] exp);
    checks++;
    if (pixel_out !== exp || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL %s: got px=%h v=%b, want px=%h v=1",
               nm, pixel_out, valid_out, exp);
    end
  endtask

  task automatic zero_chk(input string nm);
    checks++;
    if (pixel_out !== '0 || valid_out !== 1'b0 || new_frame_out !== 1'b0) begin
      errors++;
      $display("FAIL %s: got px=%h v=%b nf=%b, want all 0",
               nm, pixel_out, valid_out, new_frame_out);
    end
  endtask

  task automatic cfg(input logic [3:0] a, input logic [23:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic px(input string nm, input logic [1:0] b,
                    input logic [23:0] c, input logic [7:0] y,
                    input logic t, input logic [NL-1:0] h,
                    input logic f, input logic [23:0] exp);
    bg_sel = b;
    cam = c;
    cam_y = y;
    chan = y;
    thr = t;
    hits = h;
    nf = f;
    valid = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    valid = 1'b0;
    nf = 1'b0;
    hits = '0;
    @(negedge clk);
    lit(nm, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    zero_chk("reset_state");
    rst = 1'b0;
    @(negedge clk);

    px("cam_pass", 2'd0, 24'h123456, 8'h00, 1'b0, 4'b0000, 1'b1, 24'h123456);

    cfg(4'd14, 24'h000003);
    cfg(4'd1, 24'h0000FF);
    px("layer1", 2'd0, 24'h000000, 8'h00, 1'b0, 4'b0010, 1'b1, 24'h0000FF);
    px("layer0_prio", 2'd0, 24'h000000, 8'h00, 1'b0, 4'b0011, 1'b0, E_L0_GREEN);

    cfg(4'd0, 24'hFF0000);
    px("midframe_hold", 2'd0, 24'h000000, 8'h00, 1'b0, 4'b0001, 1'b0, E_L0_GREEN);
    px("frame_load", 2'd0, 24'h000000, 8'h00, 1'b0, 4'b0001, 1'b1, E_L0_RED);

    px("ymode_y", 2'd3, 24'h000000, 8'h40, 1'b0, 4'b0000, 1'b1, 24'h404040);
    px("ymode_mask", 2'd3, 24'h000000, 8'h40, 1'b1, 4'b0000, 1'b0, 24'hFF77AA);
    px("bgsel_hold", 2'd0, 24'hABCDEF, 8'h40, 1'b0, 4'b0000, 1'b0, 24'h404040);
    px("bgsel_load", 2'd0, 24'hABCDEF, 8'h40, 1'b0, 4'b0000, 1'b1, 24'hABCDEF);
    px("grey", 2'd1, 24'h000000, 8'h5A, 1'b0, 4'b0000, 1'b1, 24'h5A5A5A);
    px("thresh_w", 2'd2, 24'h000000, 8'h00, 1'b1, 4'b0000, 1'b1, 24'hFFFFFF);
    px("thresh_b", 2'd2, 24'h123456, 8'h00, 1'b0, 4'b0000, 1'b0, 24'h000000);

    px("blend", 2'd0, 24'h0000FE, 8'h00, 1'b0, 4'b0001, 1'b1, E_BLEND);
    px("all_hit", 2'd0, 24'h0000FE, 8'h00, 1'b0, 4'b1111, 1'b0, E_BLEND);

    cfg_we = 1'b1;
    cfg_addr = 4'd14;
    cfg_data = 24'h000004;
    px("same_cycle_load", 2'd0, 24'h000000, 8'h00, 1'b0, 4'b0101, 1'b1, 24'h00FF00);

    cfg(4'd9, 24'h111111);
    px("ignored_addr", 2'd0, 24'h000000, 8'h00, 1'b0, 4'b0100, 1'b1, 24'h00FF00);

    for (int n = 0; n < 3000; n++) begin
      valid = ($urandom_range(0, 3) != 0);
      nf = ($urandom_range(0, 39) == 0);
      bg_sel = 2'($urandom_range(0, 3));
      cam = 24'($urandom);
      cam_y = 8'($urandom);
      chan = 8'($urandom);
      thr = 1'($urandom);
      hits = NL'($urandom);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = 4'($urandom);
      cfg_data = 24'($urandom);
      @(negedge clk);
    end
    cfg_we = 1'b0;

    cfg(4'd14, 24'h00000F);
    valid = 1'b1;
    nf = 1'b1;
    hits = 4'b1111;
    @(negedge clk);
    nf = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 zero_chk("async_reset");
    valid = 1'b0;
    hits = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    px("post_reset_mask", 2'd0, 24'h555555, 8'h00, 1'b0, 4'b1111, 1'b1, 24'h555555);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
